// File: rtl/larpix_packet_rx.sv
// LArPix UART packet receiver: 2-flop synchronizer, start/data/stop/break
// framing FSM, single-entry output register with valid/ready handshake,
// parity and framing sidebands, sticky overflow and a saturating word count.
module larpix_packet_rx #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             piso,
  output logic [WIDTH-1:0] packet,
  output logic             packet_valid,
  input  logic             packet_ready,
  output logic             parity_err,
  output logic             framing_err,
  output logic             overflow,
  output logic [15:0]      rx_count
);

  localparam int unsigned IdxW = $clog2(WIDTH) + 1;

  // Start bit is re-checked half a bit in; later samples land mid-bit.
  localparam logic [7:0]      HalfLast = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]      BitLast  = 8'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(WIDTH - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  logic             sync1_q, sync2_q;
  logic             rxs;
  logic [2:0]       state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] packet_q, packet_d;
  logic             valid_q, valid_d;
  logic             parity_q, parity_d;
  logic             framing_q, framing_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      count_q, count_d;
  logic             stop_good;

  assign rxs = sync2_q;

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= piso;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: frame decoding plus output-register handshake.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    packet_d   = packet_q;
    valid_d    = valid_q;
    parity_d   = parity_q;
    framing_d  = 1'b0;
    overflow_d = overflow_q;
    count_d    = count_q;
    stop_good  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          timer_d = 8'd0;
          idx_d   = '0;
        end
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          timer_d = 8'd0;
          // A start bit gone high again was a glitch; drop it silently.
          state_d = rxs ? StIdle : StData;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StData: begin
        if (timer_q == BitLast) begin
          timer_d = 8'd0;
          shift_d = {rxs, shift_q[WIDTH-1:1]};
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == IdxLast) state_d = StStop;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StStop: begin
        if (timer_q == BitLast) begin
          timer_d = 8'd0;
          if (rxs) begin
            stop_good = 1'b1;
            state_d   = StIdle;
          end else begin
            framing_d = 1'b1;
            state_d   = StBreak;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StBreak: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A same-cycle accept frees the register for the incoming word.
    if (stop_good) begin
      if (!valid_q || packet_ready) begin
        packet_d = shift_q;
        parity_d = ~(^shift_q);
        valid_d  = 1'b1;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (valid_q && packet_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      timer_q    <= 8'd0;
      idx_q      <= '0;
      shift_q    <= '0;
      packet_q   <= '0;
      valid_q    <= 1'b0;
      parity_q   <= 1'b0;
      framing_q  <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      packet_q   <= packet_d;
      valid_q    <= valid_d;
      parity_q   <= parity_d;
      framing_q  <= framing_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  assign packet       = packet_q;
  assign packet_valid = valid_q;
  assign parity_err   = parity_q;
  assign framing_err  = framing_q;
  assign overflow     = overflow_q;
  assign rx_count     = count_q;

endmodule

// File: tb/tb_larpix_packet_rx.sv
// Bench for larpix_packet_rx: frame-level reference model with a per-cycle
// compare process, directed scenarios with literal expectations, then a
// randomized run with random consumer back-pressure.
module tb_larpix_packet_rx;

  localparam int unsigned W   = 64;
  localparam int unsigned CPB = 4;
  // Edges from driving the start bit to the stop-sample edge: 2 sync flops,
  // one edge to notice the low line, half a bit, then WIDTH+1 whole bits.
  localparam int LAT = 3 + CPB / 2 + (W + 1) * CPB;

  logic          clk          = 1'b0;
  logic          reset_n      = 1'b0;
  logic          piso         = 1'b1;
  logic          packet_ready = 1'b0;
  logic [W-1:0]  packet;
  logic          packet_valid;
  logic          parity_err;
  logic          framing_err;
  logic          overflow;
  logic [15:0]   rx_count;

  larpix_packet_rx #(
    .WIDTH       (W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .piso        (piso),
    .packet      (packet),
    .packet_valid(packet_valid),
    .packet_ready(packet_ready),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overflow    (overflow),
    .rx_count    (rx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    logic [63:0] w;
    logic        ok;
  } ev_t;

  ev_t         evq[$];
  ev_t         m_ev;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_f = 0;
  int          ready_mode = 1;
  bit          chk_en = 1'b0;
  logic        m_valid = 1'b0;
  logic [63:0] m_packet = '0;
  logic        m_parity = 1'b0;
  logic        m_fram = 1'b0;
  logic        m_over = 1'b0;
  logic [15:0] m_count = '0;
  int          valid_rises = 0;
  int          fram_pulses = 0;
  logic        valid_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each frame becomes an event at its stop-sample edge;
  // the output register follows the valid/ready delivery rules.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid  = 1'b0;
      m_packet = '0;
      m_parity = 1'b0;
      m_fram   = 1'b0;
      m_over   = 1'b0;
      m_count  = '0;
      evq.delete();
    end else begin
      cyc++;
      m_fram = 1'b0;
      if (evq.size() != 0 && evq[0].at == cyc) begin
        m_ev = evq.pop_front();
        if (m_ev.ok) begin
          if (!m_valid || packet_ready) begin
            m_packet = m_ev.w;
            m_parity = (($countones(m_ev.w) % 2) == 0);
            m_valid  = 1'b1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          end else begin
            m_over = 1'b1;
          end
        end else begin
          m_fram = 1'b1;
          if (m_valid && packet_ready) m_valid = 1'b0;
        end
      end else if (m_valid && packet_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Consumer: always low, always high, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       packet_ready = 1'b0;
      1:       packet_ready = 1'b1;
      default: packet_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Event counters for the directed scenarios.
  always @(negedge clk) begin
    if (packet_valid && !valid_prev) valid_rises++;
    if (framing_err) fram_pulses++;
    valid_prev = packet_valid;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("packet_valid", 64'(packet_valid), 64'(m_valid));
      check("framing_err", 64'(framing_err), 64'(m_fram));
      check("overflow", 64'(overflow), 64'(m_over));
      check("rx_count", 64'(rx_count), 64'(m_count));
      if (m_valid) begin
        check("packet", 64'(packet), m_packet);
        check("parity_err", 64'(parity_err), 64'(m_parity));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    piso = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] w, input logic stop_bit);
    ev_t e;
    last_f = cyc;
    e.at = cyc + LAT;
    e.w  = w;
    e.ok = stop_bit;
    evq.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < int'(W); i++) drive_bit(w[i]);
    drive_bit(stop_bit);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    piso    = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(4);
  endtask

  task automatic wait_valid(input int budget, output int at_cyc, output bit ok);
    ok     = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (packet_valid) begin
        ok     = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          at;
    bit          ok;
    int          r0, p0;
    logic [63:0] pat;
    int          r;

    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset packet_valid", 64'(packet_valid), 64'd0);
    check("reset packet", 64'(packet), 64'd0);
    check("reset parity_err", 64'(parity_err), 64'd0);
    check("reset framing_err", 64'(framing_err), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset rx_count", 64'(rx_count), 64'd0);
    realign();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    idle(4);

    // Even-weight word flags parity, one-cycle valid with ready high.
    ready_mode = 1;
    idle(2);
    send_frame(64'h8000_0000_0000_0001, 1'b1);
    wait_valid(20, at, ok);
    check("t1 valid seen", 64'(ok), 64'd1);
    check("t1 packet", 64'(packet), 64'h8000_0000_0000_0001);
    check("t1 parity_err", 64'(parity_err), 64'd1);
    check("t1 rx_count", 64'(rx_count), 64'd1);
    @(negedge clk);
    check("t1 valid one cycle", 64'(packet_valid), 64'd0);
    realign();

    // Latency from piso falling to packet_valid.
    send_frame(64'h1, 1'b1);
    wait_valid(20, at, ok);
    check("t2 valid seen", 64'(ok), 64'd1);
    check("t2 latency", 64'(at - last_f), 64'd265);
    check("t2 parity_err", 64'(parity_err), 64'd0);
    check("t2 packet", 64'(packet), 64'h1);
    realign();

    // One-cycle low glitch is rejected.
    apply_reset();
    r0 = valid_rises;
    p0 = fram_pulses;
    piso = 1'b0;
    idle(1);
    piso = 1'b1;
    idle(40);
    check("t3 no valid", 64'(valid_rises - r0), 64'd0);
    check("t3 no framing", 64'(fram_pulses - p0), 64'd0);
    check("t3 rx_count", 64'(rx_count), 64'd0);

    // Bad stop bit, long break, then a good frame.
    r0 = valid_rises;
    p0 = fram_pulses;
    send_frame(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    idle(20);
    piso = 1'b1;
    idle(2 * CPB + 4);
    check("t4 framing pulses", 64'(fram_pulses - p0), 64'd1);
    check("t4 no valid", 64'(valid_rises - r0), 64'd0);
    send_frame(64'h0123_4567_89AB_CDEF, 1'b1);
    wait_valid(20, at, ok);
    check("t4 valid seen", 64'(ok), 64'd1);
    check("t4 packet", 64'(packet), 64'h0123_4567_89AB_CDEF);
    check("t4 parity_err", 64'(parity_err), 64'd1);
    realign();

    // Back-pressure: first word held, later ones dropped.
    apply_reset();
    ready_mode = 0;
    idle(2);
    send_frame(64'h1, 1'b1);
    send_frame(64'h2, 1'b1);
    send_frame(64'h4, 1'b1);
    idle(4);
    @(negedge clk);
    check("t5 valid held", 64'(packet_valid), 64'd1);
    check("t5 packet held", 64'(packet), 64'h1);
    check("t5 overflow", 64'(overflow), 64'd1);
    check("t5 rx_count", 64'(rx_count), 64'd1);
    realign();
    ready_mode = 1;
    idle(3);
    @(negedge clk);
    check("t5 valid dropped", 64'(packet_valid), 64'd0);
    realign();

    // Reset in the middle of data bit 30.
    apply_reset();
    r0  = valid_rises;
    pat = 64'hF0F0_3C3C_5A5A_A5A5;
    drive_bit(1'b0);
    for (int i = 0; i < 30; i++) drive_bit(pat[i]);
    piso = pat[30];
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    piso    = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(6);
    send_frame(64'hA5, 1'b1);
    wait_valid(20, at, ok);
    check("t6 valid seen", 64'(ok), 64'd1);
    check("t6 packet", 64'(packet), 64'hA5);
    check("t6 parity_err", 64'(parity_err), 64'd1);
    check("t6 rx_count", 64'(rx_count), 64'd1);
    realign();
    idle(10);
    check("t6 single delivery", 64'(valid_rises - r0), 64'd1);

    // Randomized frames, glitches, breaks and consumer stalls.
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        piso = 1'b0;
        idle(1);
        piso = 1'b1;
        idle(6);
      end else if (r == 1) begin
        send_frame({$urandom, $urandom}, 1'b0);
        idle(20);
        piso = 1'b1;
        idle(2 * CPB + int'($urandom_range(0, 4)));
      end else begin
        send_frame({$urandom, $urandom}, 1'b1);
        idle(int'($urandom_range(0, 5)));
      end
    end
    ready_mode = 1;
    idle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/larpix_packet_rx.md
LARPIX_PACKET_RX -- requirements
Module: larpix_packet_rx

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 64, packet width excluding start and stop bits.
REQ-002 The block SHALL provide parameter CLKS_PER_BIT, default 4, clk cycles per UART bit; legal range 2..255.
REQ-003 The block SHALL provide port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL provide port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL provide port piso  input  1  asynchronous UART line from the chip; idle high.
REQ-006 The block SHALL provide port packet  output  WIDTH  received word, bit 0 first on the line.
REQ-007 The block SHALL provide port packet_valid  output  1  packet holds an undelivered word.
REQ-008 The block SHALL provide port packet_ready  input  1  consumer accepts the word when high with packet_valid.
REQ-009 The block SHALL provide port parity_err  output  1  sideband, valid with packet_valid: XOR of all WIDTH bits is 0 (odd parity expected).
REQ-010 The block SHALL provide port framing_err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-011 The block SHALL provide port overflow  output  1  sticky: a good word was dropped; cleared only by reset.
REQ-012 The block SHALL provide port rx_count  output  16  good (stop bit 1) words delivered to the output register; saturates at 0xFFFF.

Function
REQ-013 piso SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value (rxs).
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; bit-timer 8 bits, bit-index log2(WIDTH)+1 bits.
REQ-015 IDLE: rxs==0 -> START, timer cleared.
REQ-016 START: after CLKS_PER_BIT/2 cycles (integer divide) rxs re-sampled; 0 -> DATA, 1 -> IDLE (glitch rejected, no error).
REQ-017 DATA: rxs sampled every CLKS_PER_BIT cycles, shifted in LSB-first; after WIDTH samples -> STOP.
REQ-018 STOP: sampled CLKS_PER_BIT cycles after last data sample; 1 -> deliver and IDLE; 0 -> framing_err pulse, word discarded, -> BREAK.
REQ-019 BREAK: remain until rxs==1, then IDLE; no start detection in BREAK.
REQ-020 Deliver: if packet_valid==0 or packet_ready==1 in the stop-sample cycle, packet/parity_err load and packet_valid=1 next cycle; rx_count increments.
REQ-021 Deliver while packet_valid==1 and packet_ready==0: new word dropped, held word unchanged, overflow set, rx_count unchanged.
REQ-022 packet_valid SHALL clear the cycle after packet_valid&&packet_ready unless a new delivery occurs in that same cycle (REQ-020).
REQ-023 packet and parity_err SHALL remain stable while packet_valid==1 and not accepted.
REQ-024 Latency: packet_valid rises 1 cycle after the stop-sample cycle; stop-sample occurs (CLKS_PER_BIT/2)+(WIDTH+1)*CLKS_PER_BIT cycles after rxs falls.
REQ-025 Back-to-back frames (stop bit of minimum one bit time) SHALL be received without loss.

Reset
REQ-026 reset_n low SHALL immediately force: FSM IDLE, synchronizer flops 1, timer/index 0, packet 0, packet_valid 0, parity_err 0, framing_err 0, overflow 0, rx_count 0.
REQ-027 Reset mid-frame SHALL discard the partial word; after release a low line is treated as a new start bit.

Verification
REQ-028 CLKS_PER_BIT=4, frame 0x8000_0000_0000_0001 (odd parity false: two ones), ready=1 -> packet=0x8000_0000_0000_0001, parity_err=1, packet_valid 1 cycle, rx_count=1.
REQ-029 Frame 0x0000_0000_0000_0001, ready=1 -> parity_err=0, packet_valid at cycle 2+262+1 after piso falls (sync+REQ-024).
REQ-030 1-cycle low glitch on piso in IDLE -> no packet_valid, no framing_err, rx_count=0.
REQ-031 Frame with stop bit 0 then line held low 20 cycles -> framing_err one pulse, no packet_valid; next valid frame received correctly.
REQ-032 ready=0, three good frames 0x1,0x2,0x4 -> packet=0x1 held, overflow=1, rx_count=1; ready=1 -> accepted, valid drops.
REQ-033 reset_n low at data bit 30 then released, then a full frame 0xA5 -> only 0xA5 delivered, rx_count=1.
